// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage feeding the decoder. Owns the PC, issues one word read at a
//   time to instruction memory (req/ack) and presents each returned word to
//   decode (valid/ready). Execute can redirect the PC at any time; stale
//   in-flight data is dropped and a misaligned target parks the stage in a
//   sticky fault until reset.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_req/mem_addr    read request to imem, held until mem_ack
//   mem_ack/mem_rdata   imem response, data valid with ack
//   redirect/_pc        one-cycle PC redirect from execute
//   instr_valid/_ready  handshake to decode
//   instruction/instr_pc fetched word and its address (NOP_WORD when empty)
//   fetch_fault         sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_DISCARD = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        fault_q, fault_d;

    logic misalign;
    assign misalign = redirect && (redirect_pc[1:0] != 2'b00);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_WORD;
            ipc_q      <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state logic; redirect outranks every other event
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH: begin
                if (misalign)      state_d = S_FAULT;
                else if (redirect) state_d = mem_ack ? S_FETCH : S_DISCARD;
                else if (mem_ack)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (misalign)                     state_d = S_FAULT;
                else if (redirect || instr_ready) state_d = S_FETCH;
            end
            S_DISCARD: begin
                if (misalign)     state_d = S_FAULT;
                else if (mem_ack) state_d = S_FETCH;
            end
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_IDLE;
        endcase
    end

    // Registered-output next values
    always_comb begin
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        fault_d    = fault_q;
        unique case (state_q)
            S_IDLE: begin
                pc_d       = redirect ? redirect_pc : pc_q;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d;
            end
            S_FETCH: begin
                if (misalign) begin
                    // outstanding request must still complete; only then drop req
                    fault_d   = 1'b1;
                    valid_d   = 1'b0;
                    mem_req_d = !mem_ack;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                    if (mem_ack) mem_addr_d = redirect_pc;
                end else if (mem_ack) begin
                    instr_d   = mem_rdata;
                    ipc_d     = mem_addr_q;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    mem_req_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (misalign) begin
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP_WORD;
                end else if (redirect) begin
                    // the held word is treated as consumed; decode ignores it
                    valid_d    = 1'b0;
                    instr_d    = NOP_WORD;
                    pc_d       = redirect_pc;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_pc;
                end else if (instr_ready) begin
                    valid_d    = 1'b0;
                    instr_d    = NOP_WORD;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            S_DISCARD: begin
                if (misalign) begin
                    fault_d   = 1'b1;
                    valid_d   = 1'b0;
                    mem_req_d = !mem_ack;
                end else begin
                    if (redirect) pc_d = redirect_pc;
                    if (mem_ack) mem_addr_d = redirect ? redirect_pc : pc_q;
                end
            end
            S_FAULT: begin
                // an outstanding request drains here, then req stays low
                mem_req_d = mem_req_q && !mem_ack;
                valid_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = valid_q;
    assign instruction = instr_q;
    assign instr_pc    = ipc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed walk through the fetch scenarios, then a randomized phase with
//   random ack timing, decode back-pressure and redirects. The reference is a
//   transaction-level view: the stream of words handed to decode must be
//   consecutive addresses, restarting at the target of each redirect, with
//   each word equal to the memory image at its address.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;

    instruction_fetch #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory image: distinctive per-address word, with the test-plan word at 0x8
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h8) return 32'h0050_0093;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction
    assign mem_rdata = word(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs expected while a word is being fetched (no word held)
    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, ".req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, ".addr"}, mem_addr, addr);
        chk({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, ".pc"}, instr_pc, pc);
        chk({tag, ".instr"}, instruction, word(pc));
        chk({tag, ".req"}, {31'b0, mem_req}, 32'd0);
    endtask

    logic [31:0] exp_next;
    logic        p_req, p_ack, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_instr, p_ipc;
    int          delivered;

    initial begin
        // ---------------- reset ----------------
        step();
        chk("rst.req", {31'b0, mem_req}, 32'd0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.valid", {31'b0, instr_valid}, 32'd0);
        chk("rst.instr", instruction, NOP);
        chk("rst.ipc", instr_pc, 32'h0);
        chk("rst.fault", {31'b0, fetch_fault}, 32'd0);
        rst_n = 1'b1;
        step();                                   // IDLE -> FETCH
        chk_req("f0", 32'h0);

        // ---------------- zero wait, ready=1 ----------------
        mem_ack = 1'b1; instr_ready = 1'b1;
        step(); chk_word("w0", 32'h0);
        mem_ack = 1'b0;
        step(); chk_req("f4", 32'h4);

        // ---------------- 3 wait states on 0x4 ----------------
        for (int i = 0; i < 3; i++) begin
            step(); chk_req("wait4", 32'h4);
        end
        mem_ack = 1'b1;
        step(); chk_word("w4", 32'h4);
        mem_ack = 1'b0;
        step(); chk_req("f8", 32'h8);

        // ---------------- back-pressure on 0x8 (stray acks ignored) ----------------
        mem_ack = 1'b1;
        step(); chk_word("w8", 32'h8);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); chk_word("hold8", 32'h8);
        end
        chk("hold8.word", instruction, 32'h0050_0093);
        mem_ack = 1'b0; instr_ready = 1'b1;
        step(); chk_req("fC", 32'hC);
        mem_ack = 1'b1;
        step(); chk_word("wC", 32'hC);
        mem_ack = 1'b0;
        step(); chk_req("f10", 32'h10);

        // ---------------- redirect during wait ----------------
        redirect = 1'b1; redirect_pc = 32'h100;
        step(); chk_req("disc10", 32'h10);
        redirect = 1'b0; mem_ack = 1'b1;
        step(); chk_req("f100", 32'h100);
        step(); chk_word("w100", 32'h100);
        mem_ack = 1'b0;
        step(); chk_req("f104", 32'h104);

        // ---------------- redirect with ack same cycle ----------------
        mem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step(); chk_req("f200", 32'h200);
        redirect = 1'b0;
        step(); chk_word("w200", 32'h200);

        // ---------------- redirect in HOLD with ready=1 ----------------
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        step(); chk_req("f300", 32'h300);
        redirect = 1'b0; mem_ack = 1'b1;
        step(); chk_word("w300", 32'h300);
        mem_ack = 1'b0;
        step(); chk_req("f304", 32'h304);

        // ---------------- misaligned redirect ----------------
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h102;
        step();
        chk("flt.fault", {31'b0, fetch_fault}, 32'd1);
        chk_req("flt.out", 32'h304);               // outstanding req drains
        redirect = 1'b0; mem_ack = 1'b1;
        step();
        chk("flt.drop", {31'b0, mem_req}, 32'd0);
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flt.req", {31'b0, mem_req}, 32'd0);
            chk("flt.valid", {31'b0, instr_valid}, 32'd0);
            chk("flt.sticky", {31'b0, fetch_fault}, 32'd1);
        end
        redirect = 1'b0;

        // ---------------- async reset clears the fault ----------------
        #2 rst_n = 1'b0;
        #1;
        chk("rst2.fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst2.addr", mem_addr, 32'h0);
        chk("rst2.req", {31'b0, mem_req}, 32'd0);
        step();
        rst_n = 1'b1;
        step(); chk_req("rst2.f0", 32'h0);

        // ---------------- randomized phase ----------------
        exp_next  = 32'h0;
        delivered = 0;
        p_req = mem_req; p_addr = mem_addr; p_valid = instr_valid;
        p_instr = instruction; p_ipc = instr_pc;
        p_ack = 1'b0; p_ready = 1'b0; p_redir = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            // memory handshake: no abort, address stable while waiting
            if (p_req && !p_ack) begin
                chk("rnd.req_hold", {31'b0, mem_req}, 32'd1);
                chk("rnd.addr_hold", mem_addr, p_addr);
            end
            // held word stable until consumed or redirected away
            if (p_valid && !p_ready && !p_redir) begin
                chk("rnd.valid_hold", {31'b0, instr_valid}, 32'd1);
                chk("rnd.instr_hold", instruction, p_instr);
                chk("rnd.pc_hold", instr_pc, p_ipc);
            end
            if (p_valid && (p_ready || p_redir))
                chk("rnd.consume", {31'b0, instr_valid}, 32'd0);
            // each newly presented word continues the expected stream
            if (instr_valid && !p_valid) begin
                chk("rnd.word_pc", instr_pc, exp_next);
                chk("rnd.word_data", instruction, word(exp_next));
                exp_next = exp_next + 32'd4;
                delivered++;
            end
            if (!instr_valid) chk("rnd.nop", instruction, NOP);
            chk("rnd.fault", {31'b0, fetch_fault}, 32'd0);

            p_req = mem_req; p_addr = mem_addr; p_valid = instr_valid;
            p_instr = instruction; p_ipc = instr_pc;

            mem_ack     = ($urandom_range(0, 2) == 0);
            instr_ready = ($urandom_range(0, 1) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            if (redirect) begin
                redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                                          : ($urandom & 32'h0000_FFFC);
                exp_next = redirect_pc;
            end
            p_ack = mem_ack; p_ready = instr_ready; p_redir = redirect;
        end
        redirect = 1'b0; mem_ack = 1'b0;
        checks++;
        assert (delivered > 100) else begin
            failures++;
            $error("FAIL rnd.progress observed=%0d expected=>100", delivered);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
